// File: rtl/noc_router.sv
// 5-port wormhole mesh router with XY routing, round-robin output arbitration
// and ack/nack (void/stop) link flow control. Port index order: N, S, W, E, P.
package noc;
    typedef enum logic [0:0] {
        kFlowControlAckNack = 1'b0
    } flow_control_t;
endpackage

module noc_router #(
    parameter noc::flow_control_t flow_control = noc::kFlowControlAckNack,
    parameter int                 width        = 32,
    parameter int                 depth        = 5,
    parameter logic [4:0]         ports        = 5'b11111
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       CONST_localx,
    input  logic [2:0]       CONST_localy,
    input  logic [width-1:0] data_n_in,
    input  logic [width-1:0] data_s_in,
    input  logic [width-1:0] data_w_in,
    input  logic [width-1:0] data_e_in,
    input  logic [width-1:0] data_p_in,
    input  logic [4:0]       data_void_in,
    input  logic [4:0]       stop_in,
    output logic [width-1:0] data_n_out,
    output logic [width-1:0] data_s_out,
    output logic [width-1:0] data_w_out,
    output logic [width-1:0] data_e_out,
    output logic [width-1:0] data_p_out,
    output logic [4:0]       data_void_out,
    output logic [4:0]       stop_out
);

    localparam int               ptr_w      = (depth > 1) ? $clog2(depth) : 1;
    localparam int               cnt_w      = $clog2(depth + 1);
    localparam logic [ptr_w-1:0] last_ptr_c = ptr_w'(depth - 1);
    localparam logic [cnt_w-1:0] full_cnt_c = cnt_w'(depth);
    // A router configured with an unsupported link scheme refuses every flit.
    localparam logic             fc_ok_c    = (flow_control == noc::kFlowControlAckNack);

    // XY dimension-ordered route; returns output index N=0,S=1,W=2,E=3,P=4.
    function automatic logic [2:0] xy_route(input logic [width-1:0] flit,
                                            input logic [2:0] lx,
                                            input logic [2:0] ly);
        logic [2:0] dx;
        logic [2:0] dy;
        logic [2:0] res;
        dx = flit[23:21];
        dy = flit[20:18];
        if (dx > lx) begin
            res = 3'd3;
        end else if (dx < lx) begin
            res = 3'd2;
        end else if (dy < ly) begin
            res = 3'd0;
        end else if (dy > ly) begin
            res = 3'd1;
        end else begin
            res = 3'd4;
        end
        return res;
    endfunction

    logic [width-1:0] data_in_s [5];
    logic [width-1:0] mem_r [5][depth];
    logic [ptr_w-1:0] rd_ptr_r [5];
    logic [ptr_w-1:0] wr_ptr_r [5];
    logic [cnt_w-1:0] cnt_r [5];
    logic [cnt_w-1:0] cnt_next_s [5];
    logic [4:0]       stop_r;
    logic [4:0]       active_r;
    logic [4:0]       drop_r;
    logic [2:0]       route_r [5];
    logic [2:0]       rr_ptr_r [5];
    logic [width-1:0] out_data_r [5];
    logic [4:0]       out_valid_r;

    logic [width-1:0] front_s [5];
    logic [2:0]       head_route_s [5];
    logic [4:0]       nonempty_s;
    logic [4:0]       push_s;
    logic [4:0]       pop_s;
    logic [4:0]       discard_s;
    logic [4:0]       busy_s;
    logic [4:0]       can_send_s;
    logic [4:0]       move_s;
    logic [4:0]       grant_s;
    logic [4:0]       req_s [5];
    logic [2:0]       owner_s [5];
    logic [2:0]       win_s [5];
    logic [2:0]       src_s [5];

    assign data_in_s[0] = data_n_in;
    assign data_in_s[1] = data_s_in;
    assign data_in_s[2] = data_w_in;
    assign data_in_s[3] = data_e_in;
    assign data_in_s[4] = data_p_in;

    // Input side: FIFO front, route of a waiting head, and flits to throw away.
    always_comb begin
        for (int i = 0; i < 5; i++) begin
            front_s[i]      = mem_r[i][rd_ptr_r[i]];
            nonempty_s[i]   = (cnt_r[i] != '0);
            push_s[i]       = !data_void_in[i] && !stop_r[i];
            head_route_s[i] = xy_route(front_s[i], CONST_localx, CONST_localy);
            discard_s[i]    = nonempty_s[i] &&
                              (active_r[i] ? drop_r[i]
                                           : (!front_s[i][31] || !ports[head_route_s[i]]));
        end
    end

    // Output allocation: held wormhole grants first, otherwise round-robin among heads.
    always_comb begin
        int sum;
        int idx;
        busy_s  = '0;
        move_s  = '0;
        grant_s = '0;
        pop_s   = discard_s;
        for (int o = 0; o < 5; o++) begin
            owner_s[o]    = 3'd0;
            win_s[o]      = rr_ptr_r[o];
            src_s[o]      = 3'd0;
            req_s[o]      = '0;
            can_send_s[o] = ports[o] && (!out_valid_r[o] || !stop_in[o]);
        end
        for (int i = 0; i < 5; i++) begin
            if (active_r[i] && !drop_r[i]) begin
                busy_s[route_r[i]]  = 1'b1;
                owner_s[route_r[i]] = 3'(i);
            end else begin
                busy_s = busy_s;
            end
        end
        for (int o = 0; o < 5; o++) begin
            for (int i = 0; i < 5; i++) begin
                req_s[o][i] = !active_r[i] && nonempty_s[i] && front_s[i][31] &&
                              (head_route_s[i] == 3'(o)) && ports[o];
            end
            // Scan from farthest to nearest so the input closest to the pointer wins.
            for (int k = 4; k >= 0; k--) begin
                sum      = int'(rr_ptr_r[o]) + k;
                idx      = (sum >= 5) ? (sum - 5) : sum;
                win_s[o] = req_s[o][idx] ? 3'(idx) : win_s[o];
            end
            if (busy_s[o]) begin
                src_s[o]  = owner_s[o];
                move_s[o] = can_send_s[o] && nonempty_s[owner_s[o]];
            end else begin
                src_s[o]   = win_s[o];
                move_s[o]  = can_send_s[o] && (req_s[o] != 5'b00000);
                grant_s[o] = move_s[o];
            end
            pop_s[src_s[o]] = pop_s[src_s[o]] | move_s[o];
        end
    end

    // Next FIFO occupancy per input.
    always_comb begin
        for (int i = 0; i < 5; i++) begin
            case ({push_s[i], pop_s[i]})
                2'b10:   cnt_next_s[i] = cnt_r[i] + cnt_w'(1);
                2'b01:   cnt_next_s[i] = cnt_r[i] - cnt_w'(1);
                default: cnt_next_s[i] = cnt_r[i];
            endcase
        end
    end

    // FIFO pointers, occupancy and the registered nack to upstream.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 5; i++) begin
                rd_ptr_r[i] <= '0;
                wr_ptr_r[i] <= '0;
                cnt_r[i]    <= '0;
            end
            stop_r <= 5'b11111;
        end else begin
            for (int i = 0; i < 5; i++) begin
                if (push_s[i]) begin
                    wr_ptr_r[i] <= (wr_ptr_r[i] == last_ptr_c) ? '0 : wr_ptr_r[i] + ptr_w'(1);
                end
                if (pop_s[i]) begin
                    rd_ptr_r[i] <= (rd_ptr_r[i] == last_ptr_c) ? '0 : rd_ptr_r[i] + ptr_w'(1);
                end
                cnt_r[i]  <= cnt_next_s[i];
                stop_r[i] <= !ports[i] || !fc_ok_c || (cnt_next_s[i] == full_cnt_c);
            end
        end
    end

    // FIFO storage; contents are meaningless whenever the occupancy says empty.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 5; i++) begin
            if (push_s[i]) begin
                mem_r[i][wr_ptr_r[i]] <= data_in_s[i];
            end
        end
    end

    // Per-input packet state: a popped multi-flit head opens a packet, a tail closes it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            active_r <= '0;
            drop_r   <= '0;
            for (int i = 0; i < 5; i++) begin
                route_r[i] <= 3'd0;
            end
        end else begin
            for (int i = 0; i < 5; i++) begin
                if (pop_s[i]) begin
                    if (active_r[i]) begin
                        if (front_s[i][30]) begin
                            active_r[i] <= 1'b0;
                            drop_r[i]   <= 1'b0;
                        end
                    end else if (front_s[i][31] && !front_s[i][30]) begin
                        active_r[i] <= 1'b1;
                        drop_r[i]   <= !ports[head_route_s[i]];
                        route_r[i]  <= head_route_s[i];
                    end
                end
            end
        end
    end

    // Round-robin pointers move just past each newly granted input.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int o = 0; o < 5; o++) begin
                rr_ptr_r[o] <= 3'd0;
            end
        end else begin
            for (int o = 0; o < 5; o++) begin
                if (grant_s[o]) begin
                    rr_ptr_r[o] <= (src_s[o] == 3'd4) ? 3'd0 : src_s[o] + 3'd1;
                end
            end
        end
    end

    // Output registers: load when empty or when downstream accepted the held flit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_r <= '0;
            for (int o = 0; o < 5; o++) begin
                out_data_r[o] <= '0;
            end
        end else begin
            for (int o = 0; o < 5; o++) begin
                if (can_send_s[o]) begin
                    if (move_s[o]) begin
                        out_data_r[o]  <= front_s[src_s[o]];
                        out_valid_r[o] <= 1'b1;
                    end else begin
                        out_data_r[o]  <= '0;
                        out_valid_r[o] <= 1'b0;
                    end
                end
            end
        end
    end

    assign data_n_out    = out_data_r[0];
    assign data_s_out    = out_data_r[1];
    assign data_w_out    = out_data_r[2];
    assign data_e_out    = out_data_r[3];
    assign data_p_out    = out_data_r[4];
    assign data_void_out = ~out_valid_r;
    assign stop_out      = stop_r;

endmodule

// File: tb/tb_noc_router.sv
// Scoreboard bench for noc_router: a fully enabled router at (2,2) and a
// second one with the P port disabled.
module tb_noc_router;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_data [2][5];
    logic [4:0]  in_void [2];
    logic [4:0]  stop_in [2];
    logic [31:0] out_data [2][5];
    logic [4:0]  void_out [2];
    logic [4:0]  stop_out [2];
    logic [31:0] exp_q [2][5][$];
    logic [31:0] mon_exp;
    logic [31:0] pkt[$];
    logic [31:0] pkt_b[$];
    int          checks = 0;
    int          errors = 0;
    int          n;

    always #5 clk = ~clk;

    noc_router #(.flow_control(noc::kFlowControlAckNack), .width(32), .depth(5), .ports(5'b11111)) u_dut0 (
        .clk(clk), .rst(rst), .CONST_localx(3'd2), .CONST_localy(3'd2),
        .data_n_in(in_data[0][0]), .data_s_in(in_data[0][1]), .data_w_in(in_data[0][2]),
        .data_e_in(in_data[0][3]), .data_p_in(in_data[0][4]),
        .data_void_in(in_void[0]), .stop_in(stop_in[0]),
        .data_n_out(out_data[0][0]), .data_s_out(out_data[0][1]), .data_w_out(out_data[0][2]),
        .data_e_out(out_data[0][3]), .data_p_out(out_data[0][4]),
        .data_void_out(void_out[0]), .stop_out(stop_out[0]));

    noc_router #(.flow_control(noc::kFlowControlAckNack), .width(32), .depth(5), .ports(5'b01111)) u_dut1 (
        .clk(clk), .rst(rst), .CONST_localx(3'd2), .CONST_localy(3'd2),
        .data_n_in(in_data[1][0]), .data_s_in(in_data[1][1]), .data_w_in(in_data[1][2]),
        .data_e_in(in_data[1][3]), .data_p_in(in_data[1][4]),
        .data_void_in(in_void[1]), .stop_in(stop_in[1]),
        .data_n_out(out_data[1][0]), .data_s_out(out_data[1][1]), .data_w_out(out_data[1][2]),
        .data_e_out(out_data[1][3]), .data_p_out(out_data[1][4]),
        .data_void_out(void_out[1]), .stop_out(stop_out[1]));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_pkt(input int d, input int o, input logic [31:0] f[$]);
        foreach (f[k]) exp_q[d][o].push_back(f[k]);
    endtask

    // Offer each flit until a cycle with stop_out low carries it across an edge.
    task automatic send(input int d, input int p, input logic [31:0] f[$]);
        for (int k = 0; k < f.size(); k++) begin
            int tries;
            bit acc;
            tries = 0;
            in_data[d][p] = f[k];
            in_void[d][p] = 1'b0;
            do begin
                acc = (stop_out[d][p] == 1'b0) && rst;
                @(posedge clk); #1;
                tries++;
            end while (!acc && tries < 200);
            if (!acc) begin
                checks++;
                errors++;
                $display("FAIL send_timeout dut%0d port%0d: flit %h never accepted", d, p, f[k]);
            end
        end
        in_void[d][p] = 1'b1;
    endtask

    // Monitor: every flit that downstream takes must be the next expected one.
    always @(negedge clk) begin
        if (rst) begin
            for (int d = 0; d < 2; d++) begin
                for (int o = 0; o < 5; o++) begin
                    if (!void_out[d][o] && !stop_in[d][o]) begin
                        checks++;
                        if (exp_q[d][o].size() == 0) begin
                            errors++;
                            $display("FAIL unexpected_flit dut%0d out%0d: got %h expected none", d, o, out_data[d][o]);
                        end else begin
                            mon_exp = exp_q[d][o].pop_front();
                            if (out_data[d][o] !== mon_exp) begin
                                errors++;
                                $display("FAIL flit_order dut%0d out%0d: got %h expected %h", d, o, out_data[d][o], mon_exp);
                            end
                        end
                    end
                end
            end
            checks++;
            if (void_out[1][4] !== 1'b1 || stop_out[1][4] !== 1'b1 || out_data[1][4] !== 32'h0) begin
                errors++;
                $display("FAIL disabled_p: got void=%b stop=%b data=%h expected 1 1 0",
                         void_out[1][4], stop_out[1][4], out_data[1][4]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            in_void[d] = 5'b11111;
            stop_in[d] = 5'b00000;
            for (int p = 0; p < 5; p++) in_data[d][p] = 32'h0;
        end
        repeat (3) @(posedge clk);
        #1;
        check("reset_void", {27'h0, void_out[0]}, 32'h1F);
        check("reset_stop", {27'h0, stop_out[0]}, 32'h1F);
        check("reset_data_e", out_data[0][3], 32'h0);
        check("reset_stop_dut1", {27'h0, stop_out[1]}, 32'h1F);
        rst = 1'b1;
        @(posedge clk); #1;
        check("stop_after_reset", {27'h0, stop_out[0]}, 32'h0);
        check("stop_after_reset_dut1", {27'h0, stop_out[1]}, 32'h10);

        // P -> E, 7-flit packet, free path
        pkt = '{32'h80D80001, 32'h00000001, 32'h00000002, 32'h00000003,
                32'h00000004, 32'h00000005, 32'h40048000};
        expect_pkt(0, 3, pkt);
        fork
            send(0, 4, pkt);
            begin
                @(posedge clk); #1;
                check("first_flit_not_early", {31'h0, void_out[0][3]}, 32'h1);
                @(posedge clk); #1;
                n = 0;
                while (!void_out[0][3] && n < 20) begin
                    check("others_void", {28'h0, void_out[0][4], void_out[0][2:0]}, 32'hF);
                    n++;
                    @(posedge clk); #1;
                end
                check("e_valid_run", n, 32'd7);
            end
        join
        repeat (10) @(posedge clk);
        #1;

        // Same packet with E stalled for 10 cycles after the head reaches the output
        expect_pkt(0, 3, pkt);
        fork
            send(0, 4, pkt);
            begin
                repeat (2) @(posedge clk);
                #1;
                stop_in[0][3] = 1'b1;
                repeat (10) @(posedge clk);
                #1;
                check("stall_hold_head", out_data[0][3], 32'h80D80001);
                check("stall_p_full", {31'h0, stop_out[0][4]}, 32'h1);
                stop_in[0][3] = 1'b0;
            end
        join
        repeat (12) @(posedge clk);
        #1;

        // Route table from (2,2): (1,2)->W, (2,1)->N, (2,3)->S, (2,2)->P
        pkt = '{32'hC02800A1}; expect_pkt(0, 2, pkt); send(0, 4, pkt);
        pkt = '{32'hC04400A2}; expect_pkt(0, 0, pkt); send(0, 4, pkt);
        pkt = '{32'hC04C00A3}; expect_pkt(0, 1, pkt); send(0, 4, pkt);
        pkt = '{32'hC04800A4}; expect_pkt(0, 4, pkt); send(0, 4, pkt);
        repeat (8) @(posedge clk);
        #1;

        // N and S contend for E in the same cycle; N holds priority after P's grants
        pkt   = '{32'h80680011, 32'h00000012, 32'h40000013};
        pkt_b = '{32'h80680021, 32'h00000022, 32'h40000023};
        expect_pkt(0, 3, pkt);
        expect_pkt(0, 3, pkt_b);
        fork
            send(0, 0, pkt);
            send(0, 1, pkt_b);
        join
        repeat (12) @(posedge clk);
        #1;

        // Reset in the middle of a packet
        pkt = '{32'h80680051, 32'h00000052, 32'h00000053};
        expect_pkt(0, 3, pkt);
        send(0, 4, pkt);
        rst = 1'b0;
        #1;
        check("midreset_void", {27'h0, void_out[0]}, 32'h1F);
        check("midreset_stop", {27'h0, stop_out[0]}, 32'h1F);
        check("midreset_data_e", out_data[0][3], 32'h0);
        exp_q[0][3].delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        pkt = '{32'h80680031, 32'h40000032}; expect_pkt(0, 3, pkt); send(0, 4, pkt);
        pkt = '{32'hC02800B1};               expect_pkt(0, 2, pkt); send(0, 0, pkt);
        // Stray body with no open packet on W is dropped
        pkt = '{32'h00000099};               send(0, 2, pkt);
        repeat (8) @(posedge clk);
        #1;

        // Disabled P on dut1: packet to (2,2) vanishes, later traffic still flows
        pkt = '{32'h80480041, 32'h00000042, 32'h40000043}; send(1, 0, pkt);
        pkt = '{32'hC0680044}; expect_pkt(1, 3, pkt); send(1, 0, pkt);
        repeat (20) @(posedge clk);
        #1;

        for (int d = 0; d < 2; d++) begin
            for (int o = 0; o < 5; o++) begin
                check($sformatf("drain_d%0d_o%0d", d, o), exp_q[d][o].size(), 32'd0);
            end
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
